// File: rtl/asmi_read_arbiter_pkg.sv
// Shared types and widths for the ASMI flash read arbiter.
package flash_arb_pkg;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        ABORT  = 3'd4
    } state_t;
endpackage

// File: rtl/asmi_read_arbiter_if.sv
// Requester and ASMI engine signals of the read arbiter; master = arbiter side.
interface asmi_read_arbiter_if;
    import flash_arb_pkg::*;

    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LEN_W-1:0]  len0, len1;
    logic              ack0, ack1;
    logic              dvalid0, dvalid1;
    logic              done0, done1;
    logic              err0, err1;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] asmi_addr;
    logic              asmi_rden;
    logic              asmi_read;
    logic              asmi_reset;
    logic              asmi_busy;
    logic              asmi_data_valid;
    logic [7:0]        asmi_dataout;

    modport master (
        input  req0, req1, addr0, addr1, len0, len1,
        input  asmi_busy, asmi_data_valid, asmi_dataout,
        output ack0, ack1, dvalid0, dvalid1, done0, done1, err0, err1, rd_data,
        output asmi_addr, asmi_rden, asmi_read, asmi_reset
    );

    modport slave (
        output req0, req1, addr0, addr1, len0, len1,
        output asmi_busy, asmi_data_valid, asmi_dataout,
        input  ack0, ack1, dvalid0, dvalid1, done0, done1, err0, err1, rd_data,
        input  asmi_addr, asmi_rden, asmi_read, asmi_reset
    );
endinterface

// File: rtl/asmi_read_arbiter_rr.sv
// Two-way round-robin grant; last_grant resets to 1 so port 0 wins the first tie.
module flash_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_vld,
    output logic       gnt_idx
);
    logic last_grant;

    assign gnt_vld = |req;
    assign gnt_idx = (req == 2'b11) ? ~last_grant : req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 last_grant <= 1'b1;
        else if (en && gnt_vld)  last_grant <= gnt_idx;
    end
endmodule

// File: rtl/asmi_read_arbiter.sv
// Shares the ASMI read engine between two burst requesters, with a watchdog
// that resets a stuck engine and terminates the burst with an error.
module asmi_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT    = 4096,
    parameter int RST_CYCLES = 8
) (
    input logic               clk28,
    input logic               rst,
    asmi_read_arbiter_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam int RC_W = $clog2(RST_CYCLES) + 1;

    state_t           state;
    logic             sel;
    logic [LEN_W-1:0] len_q, cnt;
    logic [WD_W-1:0]  wd;
    logic [RC_W-1:0]  rc;
    logic             gnt_vld, gnt_idx, grant_en;
    logic             progress, wd_hit;

    assign grant_en = (state == IDLE) && !bus.asmi_busy;

    flash_rr_arb2 u_rr (
        .clk     (clk28),
        .rst     (rst),
        .req     ({bus.req1, bus.req0}),
        .en      (grant_en),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // A cycle that moves the burst forward never trips the watchdog.
    assign progress = ((state == STREAM) && bus.asmi_data_valid) ||
                      ((state == DRAIN)  && !bus.asmi_busy);
    assign wd_hit   = (wd == WD_W'(TIMEOUT - 1)) && !progress;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= 1'b0;
            len_q          <= '0;
            cnt            <= '0;
            wd             <= '0;
            rc             <= '0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.dvalid0    <= 1'b0;
            bus.dvalid1    <= 1'b0;
            bus.done0      <= 1'b0;
            bus.done1      <= 1'b0;
            bus.err0       <= 1'b0;
            bus.err1       <= 1'b0;
            bus.rd_data    <= '0;
            bus.asmi_addr  <= '0;
            bus.asmi_rden  <= 1'b0;
            bus.asmi_read  <= 1'b0;
            bus.asmi_reset <= 1'b0;
        end else begin
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.dvalid0   <= 1'b0;
            bus.dvalid1   <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.err0      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.asmi_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_en && gnt_vld) begin
                        sel           <= gnt_idx;
                        len_q         <= gnt_idx ? bus.len1 : bus.len0;
                        bus.asmi_addr <= gnt_idx ? bus.addr1 : bus.addr0;
                        bus.ack0      <= ~gnt_idx;
                        bus.ack1      <= gnt_idx;
                        bus.asmi_read <= 1'b1;
                        bus.asmi_rden <= 1'b1;
                        cnt           <= '0;
                        wd            <= '0;
                        state         <= START;
                    end
                end
                START, STREAM, DRAIN: begin
                    if (wd_hit) begin
                        bus.asmi_rden  <= 1'b0;
                        bus.asmi_reset <= 1'b1;
                        rc             <= '0;
                        state          <= ABORT;
                    end else begin
                        wd <= wd + WD_W'(1);
                        if (state == START) begin
                            state <= STREAM;
                        end else if (state == STREAM) begin
                            if (bus.asmi_data_valid) begin
                                bus.rd_data <= bus.asmi_dataout;
                                bus.dvalid0 <= ~sel;
                                bus.dvalid1 <= sel;
                                cnt         <= cnt + LEN_W'(1);
                                wd          <= '0;
                                if (cnt == len_q) begin
                                    bus.asmi_rden <= 1'b0;
                                    state         <= DRAIN;
                                end
                            end
                        end else if (!bus.asmi_busy) begin
                            bus.done0 <= ~sel;
                            bus.done1 <= sel;
                            state     <= IDLE;
                        end
                    end
                end
                ABORT: begin
                    if (rc == RC_W'(RST_CYCLES - 1)) begin
                        bus.asmi_reset <= 1'b0;
                        bus.done0      <= ~sel;
                        bus.done1      <= sel;
                        bus.err0       <= ~sel;
                        bus.err1       <= sel;
                        state          <= IDLE;
                    end else begin
                        rc <= rc + RC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asmi_read_arbiter.sv
// Directed bench for asmi_read_arbiter; expected values are hand-derived cycle by cycle.
module tb_asmi_read_arbiter;
    logic clk28 = 1'b0;
    logic rst   = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk28 = ~clk28;

    asmi_read_arbiter_if bus ();

    asmi_read_arbiter #(.TIMEOUT(16), .RST_CYCLES(8)) dut (
        .clk28 (clk28),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(negedge clk28);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.ack0, bus.ack1, bus.dvalid0, bus.dvalid1, bus.done0, bus.done1,
                bus.err0, bus.err1, bus.asmi_rden, bus.asmi_read, bus.asmi_reset,
                bus.rd_data, bus.asmi_addr};
    endfunction

    // Called at the negedge where ackN is visible; runs START, n bytes, DRAIN (busy=0).
    task automatic burst(input string tag, input int p, input int n, input logic [7:0] b0);
        bus.asmi_data_valid = 1'b1;
        bus.asmi_dataout    = b0;
        tick();
        chk({tag, "_ack_pulse"}, p ? bus.ack1 : bus.ack0, 1'b0);
        chk({tag, "_read_pulse"}, bus.asmi_read, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_dvalid"}, p ? bus.dvalid1 : bus.dvalid0, 1'b1);
            chk({tag, "_rd_data"}, bus.rd_data, 8'(b0 + i));
            chk({tag, "_rden"}, bus.asmi_rden, (i < n - 1) ? 1'b1 : 1'b0);
            bus.asmi_dataout = 8'(b0 + i + 1);
        end
        tick();
        chk({tag, "_done"}, p ? bus.done1 : bus.done0, 1'b1);
        chk({tag, "_err"}, p ? bus.err1 : bus.err0, 1'b0);
        chk({tag, "_dvalid_after"}, p ? bus.dvalid1 : bus.dvalid0, 1'b0);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.len0 = '0; bus.len1 = '0;
        bus.asmi_busy = 0; bus.asmi_data_valid = 1; bus.asmi_dataout = '0;

        tick();
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", all_outs(), 64'd0);

        // 1: single 4-byte burst on port 0
        bus.req0 = 1; bus.addr0 = 24'h012345; bus.len0 = 16'd3;
        tick();
        chk("t1_ack0", bus.ack0, 1'b1);
        chk("t1_read", bus.asmi_read, 1'b1);
        chk("t1_rden", bus.asmi_rden, 1'b1);
        chk("t1_addr", bus.asmi_addr, 24'h012345);
        bus.req0 = 0; bus.addr0 = 24'hFFFFFF; bus.len0 = 16'd9;
        burst("t1", 0, 4, 8'hA0);

        // 2: round robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0 = 1; bus.addr0 = 24'h100000; bus.len0 = 16'd1;
        bus.req1 = 1; bus.addr1 = 24'h200000; bus.len1 = 16'd0;
        tick();
        chk("t2_first_ack0", bus.ack0, 1'b1);
        chk("t2_first_ack1", bus.ack1, 1'b0);
        chk("t2_first_addr", bus.asmi_addr, 24'h100000);
        bus.req0 = 0;
        burst("t2a", 0, 2, 8'h10);
        tick();
        chk("t2_then_ack1", bus.ack1, 1'b1);
        chk("t2_then_addr", bus.asmi_addr, 24'h200000);
        bus.req1 = 0;
        burst("t2b", 1, 1, 8'h20);
        bus.req0 = 1; bus.req1 = 1;
        tick();
        chk("t2_alt_ack0", bus.ack0, 1'b1);
        chk("t2_alt_ack1_low", bus.ack1, 1'b0);
        bus.req0 = 0;
        burst("t2c", 0, 2, 8'h30);
        tick();
        chk("t2_alt_ack1", bus.ack1, 1'b1);
        bus.req1 = 0;
        burst("t2d", 1, 1, 8'h40);

        // 3: one byte, gappy data_valid, busy held in DRAIN
        bus.req1 = 1; bus.addr1 = 24'h3ABCDE; bus.len1 = 16'd0;
        tick();
        chk("t3_ack1", bus.ack1, 1'b1);
        bus.req1 = 0; bus.asmi_data_valid = 0;
        tick();
        tick();
        chk("t3_no_byte_yet", bus.dvalid1, 1'b0);
        bus.asmi_data_valid = 1; bus.asmi_dataout = 8'h5A; bus.asmi_busy = 1;
        tick();
        chk("t3_dvalid1", bus.dvalid1, 1'b1);
        chk("t3_rd_data", bus.rd_data, 8'h5A);
        chk("t3_rden_low", bus.asmi_rden, 1'b0);
        bus.asmi_dataout = 8'h77;
        for (int i = 0; i < 5; i++) begin
            bus.asmi_data_valid = (i % 2 == 0);
            tick();
            chk("t3_drain_no_dvalid", bus.dvalid1, 1'b0);
            chk("t3_drain_no_done", bus.done1, 1'b0);
        end
        bus.asmi_busy = 0;
        tick();
        chk("t3_done1", bus.done1, 1'b1);
        chk("t3_err1", bus.err1, 1'b0);
        chk("t3_rd_data_held", bus.rd_data, 8'h5A);
        bus.asmi_data_valid = 1;

        // 4: watchdog abort with data_valid stuck low
        bus.req0 = 1; bus.addr0 = 24'h0000F0; bus.len0 = 16'd7;
        bus.asmi_data_valid = 0;
        tick();
        chk("t4_ack0", bus.ack0, 1'b1);
        bus.req0 = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("t4_pre_abort_reset", bus.asmi_reset, 1'b0);
            chk("t4_pre_abort_rden", bus.asmi_rden, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_reset_high", bus.asmi_reset, 1'b1);
            chk("t4_rden_low", bus.asmi_rden, 1'b0);
            chk("t4_no_done_yet", bus.done0, 1'b0);
        end
        tick();
        chk("t4_done0", bus.done0, 1'b1);
        chk("t4_err0", bus.err0, 1'b1);
        chk("t4_reset_low", bus.asmi_reset, 1'b0);
        bus.req0 = 1; bus.addr0 = 24'h000010; bus.len0 = 16'd2;
        tick();
        chk("t4_next_ack0", bus.ack0, 1'b1);
        chk("t4_next_addr", bus.asmi_addr, 24'h000010);
        bus.req0 = 0;
        burst("t4n", 0, 3, 8'hC0);

        // 5: reset mid-stream of a 100-byte burst
        bus.req1 = 1; bus.addr1 = 24'h400000; bus.len1 = 16'd99;
        tick();
        chk("t5_ack1", bus.ack1, 1'b1);
        bus.req1 = 0; bus.asmi_dataout = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_streaming", bus.dvalid1, 1'b1);
        end
        rst = 1'b1;
        #1;
        chk("t5_async_clear", all_outs(), 64'd0);
        tick();
        tick();
        chk("t5_held_clear", all_outs(), 64'd0);
        rst = 1'b0;
        bus.req0 = 1; bus.addr0 = 24'h500000; bus.len0 = 16'd0;
        bus.req1 = 1; bus.len1 = 16'd1;
        tick();
        chk("t5_post_rst_ack0", bus.ack0, 1'b1);
        chk("t5_post_rst_ack1_low", bus.ack1, 1'b0);
        chk("t5_no_done1", bus.done1, 1'b0);
        bus.req0 = 0;
        burst("t5a", 0, 1, 8'hD0);
        tick();
        chk("t5_then_ack1", bus.ack1, 1'b1);
        bus.req1 = 0;
        burst("t5b", 1, 2, 8'hE0);

        // 6: grant held off while the engine is busy
        bus.asmi_busy = 1; bus.req1 = 1; bus.addr1 = 24'h600000; bus.len1 = 16'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_ack_busy", bus.ack1, 1'b0);
        end
        bus.asmi_busy = 0;
        tick();
        chk("t6_ack1", bus.ack1, 1'b1);
        chk("t6_addr", bus.asmi_addr, 24'h600000);
        bus.req1 = 0;
        burst("t6", 1, 1, 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
